aidc_lite_job_sched: RTL and testbench
======================================

AIDC_LITE_JOB_SCHED -- requirements
Module: aidc_lite_job_sched

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DEPTH  4  descriptor FIFO entries; power of 2, range 2..16.
  TIMEOUT_CYCLES  65535  BUSY-cycle watchdog limit; used only with the macro in REQ-030.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all logic on rising edge.
  rst  in  1  reset, synchronous, active-high.
  job_valid_i  in  1  job descriptor offered.
  job_ready_o  out  1  FIFO can accept a descriptor.
  job_src_i  in  32  source byte address.
  job_dst_i  in  32  destination byte address.
  job_len_i  in  25  length in 128B blocks (address bits 31:7).
  job_id_o  out  8  ID assigned to the descriptor offered this cycle.
  eng_src_o  out  32  source address to compression engine.
  eng_dst_o  out  32  destination address to engine.
  eng_len_o  out  25  block count to engine.
  eng_start_o  out  1  engine start, one-cycle pulse.
  eng_done_i  in  1  engine idle, level.
  cmpl_valid_o  out  1  completion record valid.
  cmpl_ready_i  in  1  completion consumer ready.
  cmpl_id_o  out  8  ID of completed job.
  cmpl_err_o  out  1  job ended by watchdog timeout.
  busy_o  out  1  FSM not IDLE or FIFO non-empty.
  count_o  out  5  FIFO occupancy, 0..DEPTH.

Function
REQ-003 Push SHALL occur when job_valid_i && job_ready_o at a rising edge; job_ready_o = (count_o < DEPTH), no same-cycle bypass while full.
REQ-004 An 8-bit ID counter SHALL be stored with each pushed descriptor, drive job_id_o continuously, increment per push, wrap 255->0.
REQ-005 FIFO SHALL be in-order; simultaneous push and pop SHALL leave count_o unchanged.
REQ-006 FSM states: IDLE, ISSUE, ARM, BUSY, CMPL.
REQ-007 IDLE: when FIFO non-empty, pop head into eng_src_o/eng_dst_o/eng_len_o and ID register; go to ISSUE if len!=0, else to CMPL (zero-length job never starts the engine).
REQ-008 ISSUE: eng_start_o=1 for exactly this cycle; go to ARM.
REQ-009 ARM: ignore eng_done_i for this one cycle (engine drops done the cycle after start); go to BUSY.
REQ-010 BUSY: on eng_done_i=1 go to CMPL with error=0.
REQ-011 CMPL: cmpl_valid_o=1 with cmpl_id_o/cmpl_err_o stable; on cmpl_ready_i=1 go to IDLE; FSM stalls while consumer not ready.
REQ-012 eng_src_o/eng_dst_o/eng_len_o SHALL be registered and stable from ISSUE through BUSY.
REQ-013 Latency: descriptor pushed into empty FIFO with FSM IDLE at edge t SHALL yield eng_start_o high in cycle t+2.
REQ-014 Back-to-back: completion handshake at edge c with FIFO non-empty SHALL yield next eng_start_o in cycle c+2.
REQ-015 Pushes SHALL remain accepted during any FSM state while not full.

Reset
REQ-020 rst=1 at a rising edge SHALL clear FSM to IDLE, FIFO to empty, ID counter to 0, watchdog to 0.
REQ-021 Reset values: job_ready_o=1, job_id_o=0, eng_start_o=0, eng_src_o/eng_dst_o/eng_len_o=0, cmpl_valid_o=0, cmpl_id_o=0, cmpl_err_o=0, busy_o=0, count_o=0.
REQ-022 Reset mid-job SHALL discard all in-flight and queued jobs without completion records.

Configuration
REQ-030 Macro AIDC_LITE_JOB_SCHED_TIMEOUT_EN defined: 32-bit watchdog cleared on ARM entry, incremented per BUSY cycle; reaching TIMEOUT_CYCLES without eng_done_i SHALL move to CMPL with cmpl_err_o=1; eng_done_i in the same cycle has priority (error=0).
REQ-031 Macro undefined: no watchdog logic; cmpl_err_o tied 0; BUSY waits indefinitely.

Verification
REQ-040 Reset, push (src=0x1000, dst=0x8000, len=2) -> job_id_o=0 at push; eng_start_o high cycle t+2 with those values; done after 50 cycles -> cmpl_valid_o, cmpl_id_o=0, cmpl_err_o=0.
REQ-041 Push 5 jobs back-to-back, engine stalled, DEPTH=4 -> job_ready_o=0 after 4th in FIFO plus 1 issued; count_o=4; completions in order IDs 0..4.
REQ-042 Push len=0 -> no eng_start_o; completion 2 cycles after push.
REQ-043 Hold cmpl_ready_i=0 for 20 cycles with 2 queued jobs -> cmpl_valid_o/cmpl_id_o stable, no eng_start_o until handshake, next start 2 cycles later.
REQ-044 With macro, TIMEOUT_CYCLES=100, eng_done_i held 0 -> cmpl_err_o=1 after 100 BUSY cycles; done and limit same cycle -> cmpl_err_o=0.
REQ-045 Assert rst during BUSY with 3 queued jobs -> next cycle count_o=0, busy_o=0, cmpl_valid_o=0; next push gets ID 0.

Source files
------------

// File: rtl/aidc_lite_job_sched.sv
// Descriptor FIFO plus single-engine job scheduler for the AIDC-lite compressor.
// Optional BUSY watchdog is enabled by defining AIDC_LITE_JOB_SCHED_TIMEOUT_EN.
module aidc_lite_job_sched #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        job_valid_i,
  output logic        job_ready_o,
  input  logic [31:0] job_src_i,
  input  logic [31:0] job_dst_i,
  input  logic [24:0] job_len_i,
  output logic [7:0]  job_id_o,
  output logic [31:0] eng_src_o,
  output logic [31:0] eng_dst_o,
  output logic [24:0] eng_len_o,
  output logic        eng_start_o,
  input  logic        eng_done_i,
  output logic        cmpl_valid_o,
  input  logic        cmpl_ready_i,
  output logic [7:0]  cmpl_id_o,
  output logic        cmpl_err_o,
  output logic        busy_o,
  output logic [4:0]  count_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("aidc_lite_job_sched: DEPTH must be a power of 2 in 2..16");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_chk
    $error("aidc_lite_job_sched: TIMEOUT_CYCLES must be non-zero");
  end

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [24:0] len;
    logic [7:0]  id;
  } desc_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ARM,
    S_BUSY,
    S_CMPL
  } state_t;

  state_t        state;
  desc_t         mem [DEPTH];
  desc_t         head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    count;
  logic [7:0]    id_cnt;
  logic          push;
  logic          pop;

  assign count_o     = count;
  assign job_id_o    = id_cnt;
  assign job_ready_o = (count < 5'(DEPTH));
  assign push        = job_valid_i && job_ready_o;
  assign pop         = (state == S_IDLE) && (count != '0);
  assign head        = mem[rd_ptr];
  assign busy_o      = (state != S_IDLE) || (count != '0);

  // Storage is not reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {job_src_i, job_dst_i, job_len_i, id_cnt};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      id_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        id_cnt <= id_cnt + 8'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef AIDC_LITE_JOB_SCHED_TIMEOUT_EN
  logic [31:0] wdog;
  logic        err_q;
  assign cmpl_err_o = err_q;
`else
  assign cmpl_err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      eng_src_o    <= '0;
      eng_dst_o    <= '0;
      eng_len_o    <= '0;
      eng_start_o  <= 1'b0;
      cmpl_valid_o <= 1'b0;
      cmpl_id_o    <= '0;
`ifdef AIDC_LITE_JOB_SCHED_TIMEOUT_EN
      wdog         <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      eng_start_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            eng_src_o <= head.src;
            eng_dst_o <= head.dst;
            eng_len_o <= head.len;
            cmpl_id_o <= head.id;
            // Zero-length jobs complete without ever touching the engine.
            if (head.len != '0) begin
              state       <= S_ISSUE;
              eng_start_o <= 1'b1;
            end else begin
              state        <= S_CMPL;
              cmpl_valid_o <= 1'b1;
`ifdef AIDC_LITE_JOB_SCHED_TIMEOUT_EN
              err_q        <= 1'b0;
`endif
            end
          end
        end
        S_ISSUE: begin
          state <= S_ARM;
`ifdef AIDC_LITE_JOB_SCHED_TIMEOUT_EN
          wdog  <= '0;
`endif
        end
        S_ARM: begin
          state <= S_BUSY;
        end
        S_BUSY: begin
          if (eng_done_i) begin
            state        <= S_CMPL;
            cmpl_valid_o <= 1'b1;
`ifdef AIDC_LITE_JOB_SCHED_TIMEOUT_EN
            err_q        <= 1'b0;
          end else if (wdog == 32'(TIMEOUT_CYCLES - 1)) begin
            state        <= S_CMPL;
            cmpl_valid_o <= 1'b1;
            err_q        <= 1'b1;
          end else begin
            wdog <= wdog + 32'd1;
`endif
          end
        end
        S_CMPL: begin
          if (cmpl_ready_i) begin
            state        <= S_IDLE;
            cmpl_valid_o <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aidc_lite_job_sched.sv
// Self-checking bench for aidc_lite_job_sched: directed scenarios then random traffic,
// compared against an event-time model of when each job pops, starts and completes.
module tb_aidc_lite_job_sched;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [31:0] job_src = '0;
  logic [31:0] job_dst = '0;
  logic [24:0] job_len = '0;
  logic [7:0]  job_id;
  logic [31:0] eng_src;
  logic [31:0] eng_dst;
  logic [24:0] eng_len;
  logic        eng_start;
  logic        eng_done = 1'b1;
  logic        cmpl_valid;
  logic        cmpl_ready = 1'b1;
  logic [7:0]  cmpl_id;
  logic        cmpl_err;
  logic        busy;
  logic [4:0]  count;

  always #5 clk = ~clk;

  aidc_lite_job_sched #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .job_valid_i(job_valid), .job_ready_o(job_ready),
    .job_src_i(job_src), .job_dst_i(job_dst), .job_len_i(job_len), .job_id_o(job_id),
    .eng_src_o(eng_src), .eng_dst_o(eng_dst), .eng_len_o(eng_len),
    .eng_start_o(eng_start), .eng_done_i(eng_done),
    .cmpl_valid_o(cmpl_valid), .cmpl_ready_i(cmpl_ready),
    .cmpl_id_o(cmpl_id), .cmpl_err_o(cmpl_err),
    .busy_o(busy), .count_o(count)
  );

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [24:0] len;
    logic [7:0]  id;
    int          lat;
  } job_t;

  job_t q[$];
  job_t cur;
  bit   cur_v;
  bit   cur_err;
  int   p_edge, c_edge, idle_since, edge_n, next_id, next_lat;
  int   lat_q[$];
  int   checks = 0;
  int   failures = 0;

  // Engine stand-in: done drops after start and rises again lat edges later.
  int eng_cnt = 0;
  always @(posedge clk) begin
    if (rst) begin
      eng_done <= 1'b1;
      eng_cnt  <= 0;
    end else if (eng_start) begin
      eng_done <= 1'b0;
      if (lat_q.size() != 0) eng_cnt <= lat_q.pop_front();
      else eng_cnt <= 3;
    end else if (!eng_done) begin
      if (eng_cnt <= 1) eng_done <= 1'b1;
      eng_cnt <= eng_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  // Job timeline: pop edge P = max(push edge, last idle edge) + 1; start visible
  // after P; completion visible after P (len 0) or P + 2 + engine latency.
  task automatic model_edge();
    bit acc;
    job_t j;
    edge_n++;
    if (rst) begin
      q.delete();
      lat_q.delete();
      cur        = '{default: 0};
      cur_v      = 1'b0;
      cur_err    = 1'b0;
      next_id    = 0;
      idle_since = edge_n;
      return;
    end
    acc = job_valid && (q.size() < int'(DEPTH));
    if (cur_v && edge_n > c_edge && cmpl_ready) begin
      cur_v      = 1'b0;
      idle_since = edge_n;
    end
    if (!cur_v && q.size() != 0 && idle_since < edge_n) begin
      cur     = q.pop_front();
      cur_v   = 1'b1;
      cur_err = 1'b0;
      p_edge  = edge_n;
      if (cur.len == '0) begin
        c_edge = edge_n;
      end else begin
        c_edge = edge_n + 2 + cur.lat;
`ifdef AIDC_LITE_JOB_SCHED_TIMEOUT_EN
        if (cur.lat > int'(TMO)) begin
          c_edge  = edge_n + 2 + int'(TMO);
          cur_err = 1'b1;
        end
`endif
      end
    end
    if (acc) begin
      j.src = job_src;
      j.dst = job_dst;
      j.len = job_len;
      j.id  = 8'(next_id);
      j.lat = next_lat;
      q.push_back(j);
      if (job_len != '0) lat_q.push_back(next_lat);
      next_id = (next_id + 1) % 256;
    end
  endtask

  task automatic check_all();
    bit in_cmpl;
    in_cmpl = cur_v && (edge_n >= c_edge);
    check("count", 32'(count), 32'(q.size()));
    check("job_ready", 32'(job_ready), 32'(q.size() < int'(DEPTH)));
    check("job_id", 32'(job_id), 32'(next_id));
    check("busy", 32'(busy), 32'(cur_v || q.size() != 0));
    check("eng_start", 32'(eng_start), 32'(cur_v && cur.len != '0 && edge_n == p_edge));
    check("eng_src", eng_src, cur.src);
    check("eng_dst", eng_dst, cur.dst);
    check("eng_len", 32'(eng_len), 32'(cur.len));
    check("cmpl_valid", 32'(cmpl_valid), 32'(in_cmpl));
    if (in_cmpl) begin
      check("cmpl_id", 32'(cmpl_id), 32'(cur.id));
      check("cmpl_err", 32'(cmpl_err), 32'(cur_err));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic offer(input logic [31:0] s, input logic [31:0] d, input logic [24:0] l,
                       input int lat);
    job_valid = 1'b1;
    job_src   = s;
    job_dst   = d;
    job_len   = l;
    next_lat  = lat;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "simulation time limit");
  end

  initial begin
    edge_n = 0; idle_since = 0; next_id = 0; next_lat = 1;
    cur = '{default: 0}; cur_v = 1'b0; cur_err = 1'b0; p_edge = 0; c_edge = 0;
    @(negedge clk);
    rst = 1'b1;
    run(2);
    check("rst_cmpl_id", 32'(cmpl_id), 32'd0);
    check("rst_cmpl_err", 32'(cmpl_err), 32'd0);
    rst = 1'b0;
    run(2);

    // Single job: src 0x1000, dst 0x8000, 2 blocks, engine busy 50 cycles.
    offer(32'h1000, 32'h8000, 25'd2, 50);
    check("first_id", 32'(job_id), 32'd0);
    tick();
    job_valid = 1'b0;
    run(60);

    // Five back-to-back pushes against a slow engine: FIFO fills behind the issued job.
    for (int unsigned i = 0; i < 5; i++) begin
      offer($urandom, $urandom, 25'($urandom_range(1, 100)), 60);
      tick();
    end
    job_valid = 1'b0;
    check("full_count", 32'(count), 32'd4);
    check("full_ready", 32'(job_ready), 32'd0);
    run(340);

    // Zero-length job completes without an engine start.
    offer(32'hA0, 32'hB0, 25'd0, 1);
    tick();
    job_valid = 1'b0;
    run(6);

    // Completion back-pressure with two jobs queued behind the one in flight.
    cmpl_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      offer($urandom, $urandom, 25'($urandom_range(1, 500)), 3);
      tick();
    end
    job_valid = 1'b0;
    run(20);
    check("stall_valid", 32'(cmpl_valid), 32'd1);
    cmpl_ready = 1'b1;
    run(30);

    // Engine latency exactly at and beyond the watchdog limit.
    offer(32'h2000, 32'h3000, 25'd7, int'(TMO));
    tick();
    job_valid = 1'b0;
    run(110);
    offer(32'h4000, 32'h5000, 25'd9, int'(TMO) + 30);
    tick();
    job_valid = 1'b0;
    run(140);

    // Reset while a job is busy and three more are queued.
    offer($urandom, $urandom, 25'd5, 40);
    tick();
    for (int unsigned i = 0; i < 3; i++) begin
      offer($urandom, $urandom, 25'd6, 4);
      tick();
    end
    job_valid = 1'b0;
    run(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_count", 32'(count), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_valid", 32'(cmpl_valid), 32'd0);
    offer(32'hC000, 32'hD000, 25'd1, 2);
    check("rst_mid_id", 32'(job_id), 32'd0);
    tick();
    job_valid = 1'b0;
    run(20);

    // Random traffic with random back-pressure and occasional reset.
    for (int unsigned i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 2) == 0)
        offer($urandom, $urandom,
              ($urandom_range(0, 3) == 0) ? 25'd0 : 25'($urandom_range(1, 32'h1FF_FFFF)),
              int'($urandom_range(1, 8)));
      else
        job_valid = 1'b0;
      cmpl_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0;
    job_valid = 1'b0;
    cmpl_ready = 1'b1;
    run(150);
    check("drained_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
